msdf_online_ctrl: RTL and testbench
===================================

Name: msdf_online_ctrl

Overview:
Parametrised control unit for the MSDF serial-parallel online multiplier datapath.
- Sequences one operation: init of the WC/WS residual registers, N input-digit steps, then DELTA zero-pad flush steps.
- Asserts P_j load and Z_j-valid strobes once the online delay has elapsed.
- Adds in/out valid-ready handshakes with back-pressure, a done pulse, a digit index, and back-to-back operation.

Parameters:
N, 9, operand length in digits; output digit count is also N.
DELTA, 3, online delay in steps; legal range 1 <= DELTA <= N, enforced by elaboration-time check.
CW, $clog2(N+DELTA), width of the step counter and digit_idx.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-low reset.
start  input  1  request a new operation; sampled in IDLE and DONE only.
in_valid  input  1  upstream input digit available.
out_ready  input  1  downstream can accept a Z_j digit.
in_ready  output  1  input digit consumed this cycle.
out_valid  output  1  Z_j digit valid (successor of ready_Zj).
load_reg_wc  output  1  initialise WC residual register.
load_reg_ws  output  1  initialise WS residual register.
load_pj  output  1  update parallel P_j register.
zero_pad  output  1  datapath must inject a zero input digit this step.
digit_idx  output  CW  current step number k.
last_zj  output  1  out_valid digit is Z_{N-1}.
busy  output  1  state is INIT or RUN.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE, step=0; all outputs 0 including digit_idx. Asynchronous assert, synchronous-clean release.
- Outputs are Moore decodes of state/step, except in_ready, out_valid and load_pj, which also use in_valid/out_ready as below.
- States:
  - IDLE -> INIT when start=1.
  - INIT: exactly 1 cycle; load_reg_wc = load_reg_ws = 1; step cleared to 0; -> RUN.
  - RUN: step k in 0..N+DELTA-1.
    - need_in = (k < N); has_out = (k >= DELTA).
    - step_en = (!need_in || in_valid) && (!has_out || out_ready).
    - in_ready = need_in && (!has_out || out_ready).
    - out_valid = has_out && (!need_in || in_valid). out_valid never depends on out_ready.
    - zero_pad = (k >= N).
    - load_pj = step_en && has_out.
    - last_zj = out_valid && k == N+DELTA-1.
    - On step_en, k increments; on step_en at k = N+DELTA-1 -> DONE.
    - Without step_en, k and state hold (stall), for any number of cycles.
  - DONE: done = 1 for 1 cycle. start=1 -> INIT (back-to-back, no IDLE bubble); else -> IDLE.
- start is ignored in INIT and RUN; no restart mid-operation.
- Counts per operation: exactly N in_ready handshakes, N out_valid&&out_ready handshakes, and DELTA zero_pad steps.
- Minimum latency with no stalls: start sampled at cycle c gives INIT at c+1, first out_valid at c+2+DELTA, done at c+N+DELTA+2.
- Reset asserted mid-operation returns to IDLE immediately with all outputs 0; no done pulse.
- digit_idx equals k in RUN and 0 in all other states.

Optional Feature:
Macro MSDF_CTRL_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in INIT or RUN: next state IDLE, step=0, no done pulse. Strobes still follow this cycle's decode.
  - abort takes priority over step_en.
  - abort in IDLE/DONE is ignored; start in DONE still behaves as specified.
- Not defined: no abort port; an operation always runs to DONE.

Decomposition:
- Package msdf_pkg: ctrl_state_t enum (IDLE, INIT, RUN, DONE) and an msdf_cw(N, DELTA) width function. It is shared with the datapath and future divider/sqrt controllers.
- Sub-module msdf_step_counter: CW-bit counter with clear/enable and terminal-count flag (k == N+DELTA-1). It also provides the k>=DELTA and k>=N compares.
- The FSM stays in msdf_online_ctrl.

Test Plan:
1. N=9, DELTA=3, in_valid = out_ready = 1, start at cycle 0 -> INIT at 1; RUN at 2..13; out_valid at 5..13 (9 digits); zero_pad at 11..13; last_zj at 13; done at 14; in_ready count 9.
2. Same, with out_ready=0 for 4 cycles at k=5 -> k holds at 5, load_pj=0 and in_ready=0 while stalled; done delayed exactly 4 cycles to 18; digit counts unchanged.
3. in_valid=0 at k=1 for 2 cycles -> no step, out_valid=0, done at 16; then start pulsed during RUN -> ignored, busy unaffected.
4. start held high through DONE -> INIT on the cycle after done; second operation done exactly N+DELTA+2 = 14 cycles after the first done.
5. rst=0 asserted at k=6 -> all outputs 0 asynchronously; after release, IDLE with no done. DELTA=N=4 instance: first out_valid at step 4 coincides with first zero_pad.
6. With MSDF_CTRL_ABORT_EN: abort at k=7 -> IDLE next cycle, done never asserted; start on the following cycle yields a clean full run.

Source files
------------

// File: rtl/msdf_pkg.sv
// Shared types and helpers for the MSDF online arithmetic controllers
// (multiplier now, divider/sqrt later).
package msdf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

  // Width needed to hold step numbers 0..n+delta-1.
  function automatic int msdf_cw(input int n, input int delta);
    return (n + delta > 1) ? $clog2(n + delta) : 1;
  endfunction

endpackage

// File: rtl/msdf_step_counter.sv
// Step counter k for the online controller: clear/enable, terminal count at
// k == N+DELTA-1, and the k >= DELTA / k >= N phase compares.
module msdf_step_counter
  import msdf_pkg::*;
#(
  parameter int N     = 9,
  parameter int DELTA = 3,
  parameter int CW    = msdf_cw(N, DELTA)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] k,
  output logic          tc,
  output logic          ge_delta,
  output logic          ge_n
);

  localparam logic [CW-1:0] K_LAST  = CW'(N + DELTA - 1);
  localparam logic [CW-1:0] K_DELTA = CW'(DELTA);
  localparam logic [CW-1:0] K_N     = CW'(N);

  logic [CW-1:0] k_q, k_d;

  always_comb begin
    k_d = k_q;
    if (clr)     k_d = '0;
    else if (en) k_d = k_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) k_q <= '0;
    else      k_q <= k_d;
  end

  assign k        = k_q;
  assign tc       = (k_q == K_LAST);
  assign ge_delta = (k_q >= K_DELTA);
  assign ge_n     = (k_q >= K_N);

endmodule

// File: rtl/msdf_online_ctrl.sv
// Control FSM for the MSDF serial-parallel online multiplier.
// Optional abort input enabled by defining MSDF_CTRL_ABORT_EN.
module msdf_online_ctrl
  import msdf_pkg::*;
#(
  parameter int N     = 9,
  parameter int DELTA = 3,
  parameter int CW    = msdf_cw(N, DELTA)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic          out_ready,
`ifdef MSDF_CTRL_ABORT_EN
  input  logic          abort,
`endif
  output logic          in_ready,
  output logic          out_valid,
  output logic          load_reg_wc,
  output logic          load_reg_ws,
  output logic          load_pj,
  output logic          zero_pad,
  output logic [CW-1:0] digit_idx,
  output logic          last_zj,
  output logic          busy,
  output logic          done
);

  if (DELTA < 1 || DELTA > N) begin : g_bad_delta
    $error("msdf_online_ctrl: DELTA must satisfy 1 <= DELTA <= N");
  end

  ctrl_state_t   state_q, state_d;
  logic [CW-1:0] k;
  logic          tc, ge_delta, ge_n;
  logic          abort_i;
  logic          run, need_in, has_out, step_en, cnt_clr, cnt_en;

`ifdef MSDF_CTRL_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  msdf_step_counter #(
    .N     (N),
    .DELTA (DELTA),
    .CW    (CW)
  ) u_step (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .k        (k),
    .tc       (tc),
    .ge_delta (ge_delta),
    .ge_n     (ge_n)
  );

  always_comb begin
    run     = (state_q == RUN);
    need_in = run && !ge_n;
    has_out = run && ge_delta;
    step_en = run && (!need_in || in_valid) && (!has_out || out_ready);

    in_ready    = need_in && (!has_out || out_ready);
    out_valid   = has_out && (!need_in || in_valid);
    zero_pad    = run && ge_n;
    load_pj     = step_en && has_out;
    last_zj     = out_valid && tc;
    load_reg_wc = (state_q == INIT);
    load_reg_ws = (state_q == INIT);
    busy        = (state_q == INIT) || run;
    done        = (state_q == DONE);
    digit_idx   = run ? k : '0;

    // k is held at zero outside RUN, so INIT always hands RUN a cleared counter.
    cnt_en  = step_en;
    cnt_clr = !run || abort_i || (step_en && tc);

    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    state_d = abort_i ? IDLE : RUN;
      RUN: begin
        if (abort_i)            state_d = IDLE;
        else if (step_en && tc) state_d = DONE;
      end
      DONE:    state_d = start ? INIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

endmodule

// File: tb/tb_msdf_online_ctrl.sv
// Directed self-checking bench for msdf_online_ctrl (N=9/DELTA=3 and N=DELTA=4);
// abort scenario included when MSDF_CTRL_ABORT_EN is defined.
module tb_msdf_online_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
`ifdef MSDF_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif

  always #5 clk = ~clk;

  logic       a_in_ready, a_out_valid, a_wc, a_ws, a_pj, a_zp, a_last, a_busy, a_done;
  logic [3:0] a_idx;
  logic       b_in_ready, b_out_valid, b_wc, b_ws, b_pj, b_zp, b_last, b_busy, b_done;
  logic [2:0] b_idx;

  msdf_online_ctrl #(.N(9), .DELTA(3), .CW(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .out_ready(out_ready),
`ifdef MSDF_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_ready(a_in_ready), .out_valid(a_out_valid), .load_reg_wc(a_wc), .load_reg_ws(a_ws),
    .load_pj(a_pj), .zero_pad(a_zp), .digit_idx(a_idx), .last_zj(a_last),
    .busy(a_busy), .done(a_done)
  );

  msdf_online_ctrl #(.N(4), .DELTA(4), .CW(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .out_ready(out_ready),
`ifdef MSDF_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_ready(b_in_ready), .out_valid(b_out_valid), .load_reg_wc(b_wc), .load_reg_ws(b_ws),
    .load_pj(b_pj), .zero_pad(b_zp), .digit_idx(b_idx), .last_zj(b_last),
    .busy(b_busy), .done(b_done)
  );

  // Monitor view of whichever instance is under test.
  bit          sel = 1'b0;
  logic        m_in_ready, m_out_valid, m_wc, m_ws, m_pj, m_zp, m_last, m_busy, m_done;
  logic [31:0] m_idx;

  always_comb begin
    if (sel) begin
      {m_in_ready, m_out_valid, m_wc, m_ws, m_pj, m_zp, m_last, m_busy, m_done} =
        {b_in_ready, b_out_valid, b_wc, b_ws, b_pj, b_zp, b_last, b_busy, b_done};
      m_idx = 32'(b_idx);
    end else begin
      {m_in_ready, m_out_valid, m_wc, m_ws, m_pj, m_zp, m_last, m_busy, m_done} =
        {a_in_ready, a_out_valid, a_wc, a_ws, a_pj, a_zp, a_last, a_busy, a_done};
      m_idx = 32'(a_idx);
    end
  end

  int errors = 0;
  int checks = 0;

  int t_done, t_first, t_last, idx_first, zp_first;
  int n_in, n_out, n_zp, n_pj, n_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] outs_vec();
    return {m_in_ready, m_out_valid, m_wc, m_ws, m_pj, m_zp, m_last, m_busy, m_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    start = 0; in_valid = 0; out_ready = 0;
`ifdef MSDF_CTRL_ABORT_EN
    abort = 0;
`endif
    #2 rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
  endtask

  // One operation starting from IDLE or DONE; t=1 is the INIT cycle.
  // Stalls: out_ready low so_n cycles at k==so_k, in_valid low si_n cycles at
  // k==si_k; start pulsed at k==st_k (must be ignored).
  task automatic op(input int so_k, input int so_n, input int si_k, input int si_n,
                    input int st_k);
    int t;
    int so_left;
    int si_left;
    so_left = so_n; si_left = si_n;
    t_done = -1; t_first = -1; t_last = -1; idx_first = -1; zp_first = -1;
    n_in = 0; n_out = 0; n_zp = 0; n_pj = 0; n_last = 0;
    start = 1; in_valid = 1; out_ready = 1;
    tick();
    start = 0;
    t = 1;
    check("init_strobes", {29'd0, m_wc, m_ws, m_busy}, 32'd7);
    while (t_done < 0 && t < 60) begin
      tick();
      t++;
      out_ready = 1; in_valid = 1; start = 0;
      if (m_busy && !m_wc && m_idx == so_k && so_left > 0) begin out_ready = 0; so_left--; end
      if (m_busy && !m_wc && m_idx == si_k && si_left > 0) begin in_valid = 0; si_left--; end
      if (m_busy && !m_wc && m_idx == st_k) start = 1;
      #1;
      if (!out_ready) begin
        check("stall_out_idx", m_idx, so_k);
        check("stall_out_load_pj", {31'd0, m_pj}, 0);
        check("stall_out_in_ready", {31'd0, m_in_ready}, 0);
      end
      if (!in_valid) begin
        check("stall_in_idx", m_idx, si_k);
        check("stall_in_out_valid", {31'd0, m_out_valid}, 0);
      end
      if (m_in_ready && in_valid) n_in++;
      if (m_out_valid && out_ready) n_out++;
      if (m_zp && out_ready) n_zp++;
      if (m_pj) n_pj++;
      if (m_last) begin n_last++; t_last = t; end
      if (m_out_valid && t_first < 0) begin
        t_first = t; idx_first = int'(m_idx); zp_first = int'(m_zp);
      end
      if (m_done) t_done = t;
    end
  endtask

  initial begin
    // Reset state (while reset asserted and after release)
    sel = 0;
    #3;
    check("reset_outs_held", {23'd0, outs_vec()}, 0);
    check("reset_idx_held", m_idx, 0);
    reset_all();
    check("reset_outs", {23'd0, outs_vec()}, 0);
    check("reset_idx", m_idx, 0);

    // 1: full-rate run
    op(-1, 0, -1, 0, -1);
    check("t1_done", t_done, 14);
    check("t1_first_ov", t_first, 5);
    check("t1_last_zj_t", t_last, 13);
    check("t1_last_zj_n", n_last, 1);
    check("t1_in_hs", n_in, 9);
    check("t1_out_hs", n_out, 9);
    check("t1_zero_pad", n_zp, 3);
    check("t1_load_pj", n_pj, 9);
    tick();
    check("t1_idle_after", {23'd0, outs_vec()}, 0);

    // 2: output back-pressure at k=5 for 4 cycles
    op(5, 4, -1, 0, -1);
    check("t2_done", t_done, 18);
    check("t2_in_hs", n_in, 9);
    check("t2_out_hs", n_out, 9);
    check("t2_load_pj", n_pj, 9);
    tick();

    // 3: input starvation at k=1 for 2 cycles, start pulsed mid-run at k=6
    op(-1, 0, 1, 2, 6);
    check("t3_done", t_done, 16);
    check("t3_in_hs", n_in, 9);
    check("t3_out_hs", n_out, 9);

    // 4: back-to-back from DONE (op() raises start during the DONE cycle)
    op(-1, 0, -1, 0, -1);
    check("t4_done_gap", t_done, 14);
    check("t4_out_hs", n_out, 9);

    // 5a: reset mid-operation at k=6
    reset_all();
    start = 1; in_valid = 1; out_ready = 1;
    tick();
    start = 0;
    for (int i = 0; i < 20 && m_idx != 6; i++) tick();
    check("t5_reached_k6", m_idx, 6);
    #2 rst = 0;
    #1;
    check("t5_async_outs", {23'd0, outs_vec()}, 0);
    check("t5_async_idx", m_idx, 0);
    #3 rst = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_idle_no_done", {30'd0, m_busy, m_done}, 0);
    end

    // 5b: N = DELTA = 4 instance
    sel = 1;
    reset_all();
    op(-1, 0, -1, 0, -1);
    check("t5b_done", t_done, 10);
    check("t5b_first_ov_idx", idx_first, 4);
    check("t5b_first_ov_zp", zp_first, 1);
    check("t5b_first_ov_t", t_first, 6);
    check("t5b_in_hs", n_in, 4);
    check("t5b_out_hs", n_out, 4);
    check("t5b_zero_pad", n_zp, 4);
    sel = 0;

`ifdef MSDF_CTRL_ABORT_EN
    // 6: abort at k=7, then a clean full run
    reset_all();
    start = 1; in_valid = 1; out_ready = 1;
    tick();
    start = 0;
    for (int i = 0; i < 20 && m_idx != 7; i++) tick();
    check("t6_reached_k7", m_idx, 7);
    abort = 1;
    #1;
    check("t6_abort_cycle_pj", {31'd0, m_pj}, 1);
    check("t6_abort_cycle_ov", {31'd0, m_out_valid}, 1);
    tick();
    abort = 0;
    check("t6_after_abort", {23'd0, outs_vec()}, 0);
    check("t6_after_abort_idx", m_idx, 0);
    tick();
    check("t6_no_done", {30'd0, m_busy, m_done}, 0);
    op(-1, 0, -1, 0, -1);
    check("t6_rerun_done", t_done, 14);
    check("t6_rerun_out_hs", n_out, 9);
    check("t6_rerun_in_hs", n_in, 9);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
